// File: rtl/wishbone_arbiter.sv
// Round-robin arbiter that lets one of N_MASTERS Wishbone masters at a time reach a single slave.
// Supports bus locking and a watchdog that terminates strobes the slave never answers.
module wishbone_arbiter #(
    parameter int unsigned N_MASTERS = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_MASTERS-1:0]      m_cyc_i,
    input  logic [N_MASTERS-1:0]      m_stb_i,
    input  logic [N_MASTERS-1:0]      m_we_i,
    input  logic [N_MASTERS-1:0]      m_lock_i,
    input  logic [32*N_MASTERS-1:0]   m_adr_i,
    input  logic [32*N_MASTERS-1:0]   m_dat_i,
    input  logic [4*N_MASTERS-1:0]    m_sel_i,
    output logic [N_MASTERS-1:0]      m_gnt_o,
    output logic [N_MASTERS-1:0]      m_ack_o,
    output logic [N_MASTERS-1:0]      m_err_o,
    output logic [N_MASTERS-1:0]      m_rty_o,
    output logic [31:0]               m_dat_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    input  logic [31:0]               s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i
);

    localparam int unsigned      IdxW   = $clog2(N_MASTERS);
    localparam logic [IdxW:0]    NumM   = (IdxW+1)'(N_MASTERS);
    localparam logic [IdxW-1:0]  LastM  = IdxW'(N_MASTERS - 1);
    localparam logic [15:0]      TmoVal = 16'(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [15:0]     wd_cnt_q, wd_cnt_d;

    logic            busy;
    logic            tmo;
    logic            resp;
    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW:0]   cand;

    assign busy    = (state_q == StBusy);
    assign tmo     = busy && (wd_cnt_q == TmoVal);
    assign resp    = s_ack_i | s_err_i | s_rty_i;
    assign m_dat_o = s_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            ptr_q    <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    // First requester at or after ptr, wrapping modulo N_MASTERS.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            cand = {1'b0, ptr_q} + (IdxW+1)'(i);
            if (cand >= NumM) begin
                cand = cand - NumM;
            end
            if (!pick_valid && m_cyc_i[cand[IdxW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        wd_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StBusy;
                    owner_d = pick_idx;
                end
            end
            StBusy: begin
                if (!m_cyc_i[owner_q] && !m_lock_i[owner_q]) begin
                    state_d = StIdle;
                    ptr_d   = (owner_q == LastM) ? '0 : owner_q + IdxW'(1);
                end else if (s_stb_o && !resp) begin
                    // s_stb_o is already low on the timeout cycle, so that cycle clears the count.
                    wd_cnt_d = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : wd_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_gnt_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (busy) begin
            m_gnt_o[owner_q] = 1'b1;
            s_cyc_o          = m_cyc_i[owner_q];
            s_stb_o          = m_stb_i[owner_q] & ~tmo;
            s_we_o           = m_we_i[owner_q];
            s_adr_o          = m_adr_i[32*owner_q +: 32];
            s_dat_o          = m_dat_i[32*owner_q +: 32];
            s_sel_o          = m_sel_i[4*owner_q +: 4];
            m_ack_o[owner_q] = s_ack_i;
            m_rty_o[owner_q] = s_rty_i;
            // A real slave response on the timeout cycle takes precedence over the watchdog error.
            m_err_o[owner_q] = s_err_i | (tmo & ~resp);
        end
    end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed scenarios plus random traffic, all checked against a
// transaction-level reference model through a per-cycle scoreboard queue.
module tb_wishbone_arbiter;

    localparam int N   = 4;
    localparam int TMO = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     m_cyc, m_stb, m_we, m_lock;
    logic [31:0]      adr  [N];
    logic [31:0]      wdat [N];
    logic [3:0]       sel  [N];
    logic [32*N-1:0]  m_adr, m_dat;
    logic [4*N-1:0]   m_sel;
    logic [N-1:0]     m_gnt_o, m_ack_o, m_err_o, m_rty_o;
    logic [31:0]      m_dat_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [31:0]      s_adr_o, s_dat_o;
    logic [3:0]       s_sel_o;
    logic [31:0]      s_dat;
    logic             s_ack, s_err, s_rty;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign m_adr[32*g +: 32] = adr[g];
        assign m_dat[32*g +: 32] = wdat[g];
        assign m_sel[4*g +: 4]   = sel[g];
    end

    wishbone_arbiter #(.N_MASTERS(N), .TIMEOUT(TMO)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_lock_i(m_lock),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_gnt_o (m_gnt_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_dat_i (s_dat),
        .s_ack_i (s_ack),
        .s_err_i (s_err),
        .s_rty_i (s_rty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] gnt, ack, err, rty;
        logic         s_cyc, s_stb, s_we;
        logic [3:0]   s_sel;
        logic [31:0]  s_adr, s_dat, m_dat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: who owns the bus, where the rotation resumes, how long the strobe waited.
    bit mdl_busy;
    int mdl_owner, mdl_ptr, mdl_wd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   o;
        bit   tmo, resp;
        e       = '0;
        e.m_dat = s_dat;
        if (rst_n && mdl_busy) begin
            o       = mdl_owner;
            tmo     = (mdl_wd == TMO);
            resp    = s_ack || s_err || s_rty;
            e.gnt[o] = 1'b1;
            e.s_cyc  = m_cyc[o];
            e.s_stb  = m_stb[o] && !tmo;
            e.s_we   = m_we[o];
            e.s_adr  = adr[o];
            e.s_dat  = wdat[o];
            e.s_sel  = sel[o];
            e.ack[o] = s_ack;
            e.rty[o] = s_rty;
            e.err[o] = s_err || (tmo && !resp);
        end
        return e;
    endfunction

    function automatic void model_update();
        int k;
        if (!rst_n) begin
            mdl_busy = 1'b0; mdl_owner = 0; mdl_ptr = 0; mdl_wd = 0;
            return;
        end
        if (!mdl_busy) begin
            mdl_wd = 0;
            for (int i = 0; i < N; i++) begin
                k = (mdl_ptr + i) % N;
                if (m_cyc[k]) begin
                    mdl_busy = 1'b1; mdl_owner = k;
                    break;
                end
            end
        end else if (!m_cyc[mdl_owner] && !m_lock[mdl_owner]) begin
            mdl_busy = 1'b0; mdl_ptr = (mdl_owner + 1) % N; mdl_wd = 0;
        end else if (mdl_wd == TMO) begin
            mdl_wd = 0;
        end else if (m_stb[mdl_owner] && !(s_ack || s_err || s_rty)) begin
            mdl_wd = (mdl_wd < 65535) ? mdl_wd + 1 : mdl_wd;
        end else begin
            mdl_wd = 0;
        end
    endfunction

    // Push this cycle's expectation, cross the clock edge, advance the model, land at edge+1.
    task automatic step();
        exp_q.push_back(model_out());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic look(); #2; endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("gnt", 32'(m_gnt_o), 32'(mon_e.gnt));
            chk("resp", 32'({m_ack_o, m_err_o, m_rty_o}), 32'({mon_e.ack, mon_e.err, mon_e.rty}));
            chk("s_ctl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}),
                32'({mon_e.s_cyc, mon_e.s_stb, mon_e.s_we, mon_e.s_sel}));
            chk("s_adr", s_adr_o, mon_e.s_adr);
            chk("s_dat", s_dat_o, mon_e.s_dat);
            chk("m_dat", m_dat_o, mon_e.m_dat);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
        for (int k = 0; k < N; k++) begin
            adr[k] = 32'h1000_0000 + 32'(k); wdat[k] = 32'hA000_0000 + 32'(k); sel[k] = 4'(k + 1);
        end
        mdl_busy = 1'b0; mdl_owner = 0; mdl_ptr = 0; mdl_wd = 0;
        @(posedge clk); #1;
        look(); chk("reset_gnt", 32'(m_gnt_o), 32'd0);
        step(); step();
        rst_n = 1'b1;

        // Round robin with everybody requesting: 0,1,2,3,0 with an idle cycle between grants.
        m_cyc = '1; m_stb = '1;
        look(); chk("rr_first_idle", 32'(m_gnt_o), 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            s_ack = 1'b1;
            look(); chk("rr_gnt", 32'(m_gnt_o), 32'(1 << (k % N)));
            chk("rr_ack", 32'(m_ack_o), 32'(1 << (k % N)));
            step();
            s_ack = 1'b0; m_cyc[k % N] = 1'b0;
            step();
            m_cyc = (k == 4) ? '0 : '1;
            look(); chk("rr_idle", 32'(m_gnt_o), 32'd0);
            step();
        end

        // Move ptr to 2, then only masters 0 and 1 request: search wraps to master 0.
        m_cyc = 4'b0010; step();
        m_cyc = 4'b0000; look(); chk("ptr_setup", 32'(m_gnt_o), 32'b0010); step();
        m_cyc = 4'b0011; step();
        look(); chk("ptr_wrap", 32'(m_gnt_o), 32'b0001); step();
        m_cyc = '0; step();

        // Locked master 1 keeps the grant while it drops cyc and master 0 waits.
        m_cyc = 4'b0010; step();
        m_lock = 4'b0010; m_cyc = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            look(); chk("lock_hold", 32'(m_gnt_o), 32'b0010);
            chk("lock_s_cyc", 32'(s_cyc_o), 32'd0);
            step();
        end
        m_lock = '0;
        look(); chk("lock_last", 32'(m_gnt_o), 32'b0010); step();
        look(); chk("lock_idle", 32'(m_gnt_o), 32'd0); step();
        look(); chk("lock_next", 32'(m_gnt_o), 32'b0001); step();
        m_cyc = '0; step();

        // Watchdog: silent slave, error on the fifth strobe cycle with strobe suppressed.
        m_cyc = 4'b0100; m_stb = 4'b0100; step();
        for (int i = 1; i <= 6; i++) begin
            look();
            chk("wd_err", 32'(m_err_o), (i == 5) ? 32'b0100 : 32'd0);
            chk("wd_stb", 32'(s_stb_o), (i == 5) ? 32'd0 : 32'd1);
            step();
        end
        m_cyc = '0; step();

        // Read by master 3: ack routed only to it, data broadcast.
        m_cyc = 4'b1000; m_stb = 4'b1000; m_we = '0; step();
        s_dat = 32'hDEADBEEF; s_ack = 1'b1;
        look(); chk("rd_ack", 32'(m_ack_o), 32'b1000); chk("rd_dat", m_dat_o, 32'hDEADBEEF);
        step();
        s_ack = 1'b0; m_cyc = '0; step();

        // Reset in the middle of a strobe, then master 0 wins with all requesting.
        m_cyc = 4'b0100; m_stb = 4'b0100; step();
        look(); chk("pre_rst_stb", 32'(s_stb_o), 32'd1); step();
        rst_n = 1'b0; m_cyc = '1; m_stb = '1;
        look(); chk("rst_gnt", 32'(m_gnt_o), 32'd0); chk("rst_stb", 32'(s_stb_o), 32'd0);
        chk("rst_cyc", 32'(s_cyc_o), 32'd0); chk("rst_adr", s_adr_o, 32'd0);
        step();
        rst_n = 1'b1;
        look(); chk("post_rst_idle", 32'(m_gnt_o), 32'd0); step();
        look(); chk("post_rst_gnt", 32'(m_gnt_o), 32'b0001); step();
        m_cyc = '0; step();

        // Random traffic: a lively slave first, then a mostly silent one to provoke timeouts.
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(3) == 0) m_cyc[k] = ~m_cyc[k];
                m_stb[k]  = m_cyc[k] && ($urandom_range(7) != 0);
                m_lock[k] = ($urandom_range(7) == 0);
                m_we[k]   = 1'($urandom);
                adr[k]    = $urandom; wdat[k] = $urandom; sel[k] = 4'($urandom);
            end
            s_ack = (c < 1000) ? ($urandom_range(5) == 0) : ($urandom_range(31) == 0);
            s_err = ($urandom_range(31) == 0);
            s_rty = ($urandom_range(31) == 0);
            s_dat = $urandom;
            rst_n = ($urandom_range(199) != 0);
            step();
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
